nest_checker: RTL and testbench
===============================

# nest_checker

Streaming, case-insensitive checker for nested `begin`/`end` and `fork`/`join` keyword pairs in an 8-bit ASCII character stream. It sits after the character source in the text-checker path and is the parametrised successor of the single-pair block checker. It adds:
- a typed nesting stack of configurable depth;
- mismatch and overflow detection;
- a per-character valid qualifier, a synchronous clear, and error reporting.

## Interface
- `DEPTH`, 16: maximum nesting depth; must be ≥ 1. Localparam `DW = $clog2(DEPTH+1)`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: **asynchronous, active-low** reset.
- `clear` input 1: synchronous clear, same effect as reset. Takes priority over `in_valid`.
- `in_valid` input 1: `in` is consumed on this edge. There is no backpressure; the block is always ready.
- `in` input 8: ASCII character.
- `result` output 1: stream is balanced and error-free if the current word ended now.
- `depth` output DW: committed nesting depth.
- `err` output 1: sticky error flag.
- `err_code` output 2: first error. 0 NONE, 1 UNDERFLOW, 2 OVERFLOW, 3 MISMATCH.

## Operation
- **Word:** a maximal run of non-space characters. The only separator is 0x20; all other bytes, including tab and CR, are word characters.
- **Letters:** matching is case-insensitive.
- **Keywords:** exactly `begin`, `end`, `fork`, `join`, with distinct first letters b/e/f/j. Any longer word, e.g. `ending`, is not a keyword.
- **Tokenizer states:**
  - IDLE (at word start): on space, stay IDLE. On b/e/f/j, go to MATCH(kw, idx=1). On any other char, go to SKIP.
  - MATCH: next char equals `kw[idx]` → idx+1. On the last letter, go to FULL(kw). Any other char → SKIP. A space → IDLE (partial word, no commit).
  - FULL(kw): on space, commit kw and go to IDLE. On non-space, go to SKIP.
  - SKIP: on space, go to IDLE; otherwise stay in SKIP.
- **Commit:**
  - `begin` pushes type B; `fork` pushes type F.
  - If depth == DEPTH, the push is dropped and OVERFLOW is raised.
  - `end`/`join` with depth 0 → UNDERFLOW.
  - `end`/`join` whose top type differs (end needs B, join needs F) → MISMATCH, with no pop.
  - Otherwise, pop.
- **Sticky error:** the first error sets `err` and latches `err_code`. Later errors do not change the code. Stack updates continue after an error, but `result` stays 0 until reset or clear.
- **`result` (tentative view):**
  - 1 iff `err` == 0 and one of the following holds:
    - (state ≠ FULL and depth == 0);
    - (state == FULL(end/join), depth == 1, and the top type matches).
  - FULL(begin/fork) or an invalid pending close gives 0.
  - A following non-space character revokes the pending keyword. `result` then reverts to the committed view.
- **Stack:** DEPTH×1-bit type storage plus a DW-bit pointer. Pointer arithmetic never wraps: it saturates at 0 and DEPTH via the error rules.

## Timing
- All state updates happen on the `clk` rising edge when `in_valid`=1. With `in_valid`=0, all state holds.
- Outputs are functions of registered state only; there is no combinational path from `in`. Latency: `result` reflects every character accepted up to and including the last edge.
- **Reset** (async assert, low) and **clear** (sync):
  - Tokenizer goes to IDLE and the stack is emptied.
  - Output values: `depth`=0, `err`=0, `err_code`=0, `result`=1.
  - Reset mid-word discards the partial word immediately, without waiting for a clock.
- **Simultaneous events:**
  - `clear` with `in_valid`: the character is dropped.
  - Overflow on a push: depth stays at DEPTH.
  - MISMATCH and UNDERFLOW cannot coincide.
- End of stream needs no terminator. `result` already reports the tentative view.

## Structure
- Package `nest_pkg`:
  - keyword enum {KW_BEGIN, KW_END, KW_FORK, KW_JOIN};
  - tokenizer state enum {IDLE, MATCH, FULL, SKIP};
  - error-code constants;
  - stack type constants B=0, F=1;
  - lowercase-fold function.
- Sub-module `nest_tokenizer`: char → {tok_state, kw, commit pulse}. The top module holds the stack, error logic and `result`.

## Test plan
- DEPTH=16, feed `begin fork join end ` → `depth` sequence 1,2,1,0. `result`=0 from the 'n' of `begin` until the 'd' of `end`, then 1. `err`=0.
- Feed `END` → `result`=0 after 'D' (pending UNDERFLOW). Then feed `x` → `result`=1, `err`=0. Then feed ` end ` → `err`=1, `err_code`=1, `result`=0 until clear.
- Feed `begin fork end ` → `err_code`=3, `depth`=2, `result`=0. Assert `clear` one cycle → `depth`=0, `result`=1.
- DEPTH=2, feed `Begin BEGIN begin ` → `depth`=2, `err_code`=2. Subsequent `end end ` → `depth`=0 but `result` stays 0.
- Interleave `in_valid`=0 cycles with garbage on `in` inside `begin ending end ` → garbage ignored, `ending` not a keyword, final `depth`=0, `result`=1.
- Pull `reset` low asynchronously mid-`fork` between clock edges → all outputs at reset values before the next edge. After release, `join ` → UNDERFLOW.

Source files
------------

// File: rtl/nest_pkg.sv
// nest_pkg
// Shared types and helpers for the nested begin/end, fork/join checker.
// Contents:
//   kw_e          - the four recognised keywords
//   tok_state_e   - tokenizer states
//   ERR_*         - error codes reported on err_code
//   TYPE_B/TYPE_F - one-bit stack entry types (begin-type / fork-type)
//   fold_lower    - ASCII lowercase fold for case-insensitive matching
//   kw_letter     - letter idx of a keyword (lowercase)
//   kw_last       - index of the last letter of a keyword
//   kw_is_close   - end/join close a block, begin/fork open one
//   kw_type       - stack type a keyword pushes or expects on top
package nest_pkg;

  typedef enum logic [1:0] {KW_BEGIN, KW_END, KW_FORK, KW_JOIN} kw_e;

  typedef enum logic [1:0] {IDLE, MATCH, FULL, SKIP} tok_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_MISMATCH  = 2'd3;

  localparam logic TYPE_B = 1'b0;
  localparam logic TYPE_F = 1'b1;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  function automatic logic [7:0] fold_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      return c | 8'h20;
    end
    return c;
  endfunction

  function automatic logic [7:0] kw_letter(input kw_e kw, input logic [2:0] idx);
    logic [7:0] l;
    l = 8'h00;
    case (kw)
      KW_BEGIN: begin
        case (idx)
          3'd0: l = "b";
          3'd1: l = "e";
          3'd2: l = "g";
          3'd3: l = "i";
          3'd4: l = "n";
          default: l = 8'h00;
        endcase
      end
      KW_END: begin
        case (idx)
          3'd0: l = "e";
          3'd1: l = "n";
          3'd2: l = "d";
          default: l = 8'h00;
        endcase
      end
      KW_FORK: begin
        case (idx)
          3'd0: l = "f";
          3'd1: l = "o";
          3'd2: l = "r";
          3'd3: l = "k";
          default: l = 8'h00;
        endcase
      end
      KW_JOIN: begin
        case (idx)
          3'd0: l = "j";
          3'd1: l = "o";
          3'd2: l = "i";
          3'd3: l = "n";
          default: l = 8'h00;
        endcase
      end
      default: l = 8'h00;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] kw_last(input kw_e kw);
    logic [2:0] n;
    case (kw)
      KW_BEGIN: n = 3'd4;
      KW_END:   n = 3'd2;
      default:  n = 3'd3;
    endcase
    return n;
  endfunction

  function automatic logic kw_is_close(input kw_e kw);
    return (kw == KW_END) || (kw == KW_JOIN);
  endfunction

  function automatic logic kw_type(input kw_e kw);
    return ((kw == KW_FORK) || (kw == KW_JOIN)) ? TYPE_F : TYPE_B;
  endfunction

endpackage

// File: rtl/nest_tokenizer.sv
// nest_tokenizer
// Splits the character stream into space-separated words and recognises
// the keywords begin/end/fork/join case-insensitively.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear, wins over in_valid
//   in_valid - consume in on this edge
//   in       - ASCII character
//   state    - registered tokenizer state
//   kw       - keyword being matched / fully matched (meaningful in MATCH/FULL)
//   commit   - high on the edge that terminates a complete keyword with a space
module nest_tokenizer
  import nest_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in,
  output tok_state_e state,
  output kw_e        kw,
  output logic       commit
);

  tok_state_e state_q, state_d;
  kw_e        kw_q, kw_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] ch;

  assign ch = fold_lower(in);

  // State register: a clear behaves exactly like reset, and the character
  // presented alongside it is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kw_q    <= KW_BEGIN;
      idx_q   <= 3'd0;
    end else if (clear) begin
      state_q <= IDLE;
      kw_q    <= KW_BEGIN;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      kw_q    <= kw_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: the first letter picks the only possible keyword
  // since the four keywords start with distinct letters; after that each
  // letter must match in order or the rest of the word is skipped.
  always_comb begin
    state_d = state_q;
    kw_d    = kw_q;
    idx_d   = idx_q;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in == CHAR_SPACE) begin
            state_d = IDLE;
          end else if (ch == "b") begin
            state_d = MATCH;
            kw_d    = KW_BEGIN;
            idx_d   = 3'd1;
          end else if (ch == "e") begin
            state_d = MATCH;
            kw_d    = KW_END;
            idx_d   = 3'd1;
          end else if (ch == "f") begin
            state_d = MATCH;
            kw_d    = KW_FORK;
            idx_d   = 3'd1;
          end else if (ch == "j") begin
            state_d = MATCH;
            kw_d    = KW_JOIN;
            idx_d   = 3'd1;
          end else begin
            state_d = SKIP;
          end
        end
        MATCH: begin
          if (in == CHAR_SPACE) begin
            state_d = IDLE;
          end else if (ch == kw_letter(kw_q, idx_q)) begin
            if (idx_q == kw_last(kw_q)) begin
              state_d = FULL;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            state_d = SKIP;
          end
        end
        FULL: begin
          state_d = (in == CHAR_SPACE) ? IDLE : SKIP;
        end
        SKIP: begin
          state_d = (in == CHAR_SPACE) ? IDLE : SKIP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: the commit pulse is the space that closes a full keyword.
  always_comb begin
    state  = state_q;
    kw     = kw_q;
    commit = in_valid && !clear && (state_q == FULL) && (in == CHAR_SPACE);
  end

endmodule

// File: rtl/nest_checker.sv
// nest_checker
// Streaming checker for nested begin/end and fork/join pairs.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear (same effect as reset), wins over in_valid
//   in_valid - consume in on this edge (no backpressure)
//   in       - ASCII character
//   result   - stream balanced and error-free if the current word ended now
//   depth    - committed nesting depth
//   err      - sticky error flag
//   err_code - first error: 0 none, 1 underflow, 2 overflow, 3 mismatch
module nest_checker
  import nest_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          result,
  output logic [DW-1:0] depth,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

  tok_state_e tok_state;
  kw_e        tok_kw;
  logic       commit;

  logic [DEPTH-1:0] stack_q, stack_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       new_err;
  logic             top_type;

  nest_tokenizer u_tokenizer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in       (in),
    .state    (tok_state),
    .kw       (tok_kw),
    .commit   (commit)
  );

  // Type of the entry on top of the stack; zero when the stack is empty,
  // callers only look at it with depth > 0.
  always_comb begin
    top_type = TYPE_B;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) begin
        top_type = stack_q[i];
      end
    end
  end

  // Commit handling: an overflowing push is dropped and a mismatched close
  // leaves the stack untouched, so the pointer never leaves 0..DEPTH.
  // Stack updates keep going after an error; only the first error code is kept.
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    new_err = ERR_NONE;
    if (commit) begin
      if (!kw_is_close(tok_kw)) begin
        if (depth_q == DEPTH_MAX) begin
          new_err = ERR_OVERFLOW;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_q) begin
              stack_d[i] = kw_type(tok_kw);
            end
          end
          depth_d = depth_q + DEPTH_ONE;
        end
      end else begin
        if (depth_q == '0) begin
          new_err = ERR_UNDERFLOW;
        end else if (top_type != kw_type(tok_kw)) begin
          new_err = ERR_MISMATCH;
        end else begin
          depth_d = depth_q - DEPTH_ONE;
        end
      end
    end
    err_d  = err_q | (new_err != ERR_NONE);
    code_d = err_q ? code_q : new_err;
  end

  // Stack, pointer and error registers; clear empties everything like reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stack_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else if (clear) begin
      stack_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Tentative result: a fully matched close keyword is evaluated as if the
  // word had already ended, a fully matched open keyword always unbalances.
  always_comb begin
    logic committed_ok;
    logic pending_ok;
    committed_ok = (tok_state != FULL) && (depth_q == '0);
    pending_ok   = (tok_state == FULL) && kw_is_close(tok_kw) &&
                   (depth_q == DEPTH_ONE) && (top_type == kw_type(tok_kw));
    result   = !err_q && (committed_ok || pending_ok);
    depth    = depth_q;
    err      = err_q;
    err_code = code_q;
  end

endmodule

// File: tb/tb_nest_checker.sv
// tb_nest_checker
// Drives two checkers (DEPTH=16 and DEPTH=2) with the same character stream
// and compares them against a word-level reference model.
module tb_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_ch;

  logic       result16, err16, result2, err2;
  logic [4:0] depth16;
  logic [1:0] depth2;
  logic [1:0] code16, code2;

  logic [8:0] act16, act2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the current word plus a stack per instance.
  string       kws[4] = '{"begin", "end", "fork", "join"};
  byte unsigned wbuf[8];
  int          wlen;
  int          cap[2] = '{16, 2};
  int          md[2];
  bit          stk[2][16];
  bit          merr[2];
  int          mcode[2];

  always #5 clk = ~clk;

  nest_checker #(.DEPTH(16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in       (in_ch),
    .result   (result16),
    .depth    (depth16),
    .err      (err16),
    .err_code (code16)
  );

  nest_checker #(.DEPTH(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in       (in_ch),
    .result   (result2),
    .depth    (depth2),
    .err      (err2),
    .err_code (code2)
  );

  assign act16 = {result16, depth16, err16, code16};
  assign act2  = {result2, 3'b000, depth2, err2, code2};

  function automatic byte unsigned lower(input byte unsigned c);
    return (c >= 65 && c <= 90) ? byte'(c + 32) : c;
  endfunction

  // Index of the keyword the current partial word spells exactly, or -1.
  function automatic int classify();
    for (int k = 0; k < 4; k++) begin
      if (wlen == kws[k].len()) begin
        bit same = 1'b1;
        for (int j = 0; j < wlen; j++) begin
          if (lower(wbuf[j]) != kws[k][j]) same = 1'b0;
        end
        if (same) return k;
      end
    end
    return -1;
  endfunction

  // begin/end pair with type 0, fork/join with type 1.
  function automatic bit kind_type(input int k);
    return (k == 2 || k == 3);
  endfunction

  function automatic void model_reset();
    wlen = 0;
    for (int i = 0; i < 2; i++) begin
      md[i] = 0;
      merr[i] = 1'b0;
      mcode[i] = 0;
      for (int j = 0; j < 16; j++) stk[i][j] = 1'b0;
    end
  endfunction

  function automatic void model_commit(input int inst, input int k);
    int e = 0;
    if (k == 0 || k == 2) begin
      if (md[inst] == cap[inst]) e = 2;
      else begin
        stk[inst][md[inst]] = kind_type(k);
        md[inst]++;
      end
    end else begin
      if (md[inst] == 0) e = 1;
      else if (stk[inst][md[inst]-1] != kind_type(k)) e = 3;
      else md[inst]--;
    end
    if (e != 0 && !merr[inst]) begin
      merr[inst] = 1'b1;
      mcode[inst] = e;
    end
  endfunction

  function automatic void model_char(input byte unsigned c);
    if (c == 8'h20) begin
      int k = classify();
      if (k >= 0) begin
        model_commit(0, k);
        model_commit(1, k);
      end
      wlen = 0;
    end else begin
      if (wlen < 8) wbuf[wlen] = c;
      wlen++;
    end
  endfunction

  // Expected output vector {result, depth, err, err_code} for an instance.
  function automatic logic [8:0] expv(input int inst);
    logic r = 1'b0;
    int k;
    if (!merr[inst]) begin
      k = classify();
      if (k == 0 || k == 2) r = 1'b0;
      else if (k == 1 || k == 3)
        r = (md[inst] == 1) && (stk[inst][0] == kind_type(k));
      else r = (md[inst] == 0);
    end
    return {r, 5'(md[inst]), merr[inst], 2'(mcode[inst])};
  endfunction

  task automatic applyStimulus(input byte unsigned c, input bit v);
    @(negedge clk);
    in_ch = c;
    in_valid = v;
    clear = 1'b0;
    @(posedge clk);
    #1;
    if (v) model_char(c);
  endtask

  task automatic applyClear();
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_ch = "e";
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_ch = 8'h00;
    model_reset();
    #12;
    n_vec++;
    if (act16 !== 9'b1_00000_0_00) begin
      n_err++;
      $display("[TB] FAIL reset_hold16 got %b want %b", act16, 9'b1_00000_0_00);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (act2 !== 9'b1_00000_0_00) begin
      n_err++;
      $display("[TB] FAIL reset_release2 got %b want %b", act2, 9'b1_00000_0_00);
    end
  endtask

  task automatic test_balanced();
    string s = "begin fork join end ";
    applyClear();
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], 1'b1);
      n_vec++;
      if (act16 !== expv(0) || act2 !== expv(1)) begin
        n_err++;
        $display("[TB] FAIL balanced char %0d got %b/%b want %b/%b", i, act16, act2, expv(0), expv(1));
      end
    end
    n_vec++;
    if (depth16 !== 5'd0 || result16 !== 1'b1 || err16 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL balanced_final got d=%0d r=%b e=%b want d=0 r=1 e=0", depth16, result16, err16);
    end
  endtask

  task automatic test_underflow();
    string s = "END x end ";
    applyClear();
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], 1'b1);
      n_vec++;
      if (act16 !== expv(0) || act2 !== expv(1)) begin
        n_err++;
        $display("[TB] FAIL underflow char %0d got %b/%b want %b/%b", i, act16, act2, expv(0), expv(1));
      end
      if (i == 2) begin
        n_vec++;
        if (result16 !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL pending_underflow got %b want 0", result16);
        end
      end
    end
    n_vec++;
    if (err16 !== 1'b1 || code16 !== 2'd1 || result16 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL underflow_final got e=%b c=%0d r=%b want e=1 c=1 r=0", err16, code16, result16);
    end
  endtask

  task automatic test_mismatch_clear();
    string s = "begin fork end ";
    applyClear();
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], 1'b1);
      n_vec++;
      if (act16 !== expv(0) || act2 !== expv(1)) begin
        n_err++;
        $display("[TB] FAIL mismatch char %0d got %b/%b want %b/%b", i, act16, act2, expv(0), expv(1));
      end
    end
    n_vec++;
    if (code16 !== 2'd3 || depth16 !== 5'd2 || result16 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mismatch_final got c=%0d d=%0d r=%b want c=3 d=2 r=0", code16, depth16, result16);
    end
    applyClear();
    n_vec++;
    if (act16 !== 9'b1_00000_0_00 || act2 !== 9'b1_00000_0_00) begin
      n_err++;
      $display("[TB] FAIL after_clear got %b/%b want %b", act16, act2, 9'b1_00000_0_00);
    end
  endtask

  task automatic test_overflow();
    string s = "Begin BEGIN begin end end ";
    applyClear();
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], 1'b1);
      n_vec++;
      if (act16 !== expv(0) || act2 !== expv(1)) begin
        n_err++;
        $display("[TB] FAIL overflow char %0d got %b/%b want %b/%b", i, act16, act2, expv(0), expv(1));
      end
      if (i == 17) begin
        n_vec++;
        if (depth2 !== 2'd2 || code2 !== 2'd2) begin
          n_err++;
          $display("[TB] FAIL overflow_point got d=%0d c=%0d want d=2 c=2", depth2, code2);
        end
      end
    end
    n_vec++;
    if (depth2 !== 2'd0 || result2 !== 1'b0 || depth16 !== 5'd1) begin
      n_err++;
      $display("[TB] FAIL overflow_final got d2=%0d r2=%b d16=%0d want 0 0 1", depth2, result2, depth16);
    end
  endtask

  task automatic test_valid_gaps();
    string s = "begin ending end ";
    applyClear();
    for (int i = 0; i < s.len(); i++) begin
      if ($urandom_range(1) == 1) applyStimulus(8'($urandom_range(255)), 1'b0);
      applyStimulus(s[i], 1'b1);
      n_vec++;
      if (act16 !== expv(0) || act2 !== expv(1)) begin
        n_err++;
        $display("[TB] FAIL gaps char %0d got %b/%b want %b/%b", i, act16, act2, expv(0), expv(1));
      end
    end
    applyStimulus("d", 1'b0);
    n_vec++;
    if (depth16 !== 5'd0 || result16 !== 1'b1 || err16 !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL gaps_final got d=%0d r=%b e=%b want d=0 r=1 e=0", depth16, result16, err16);
    end
  endtask

  task automatic test_async_reset();
    string s = "begin fork";
    string t = "join ";
    applyClear();
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (act16 !== 9'b1_00000_0_00 || act2 !== 9'b1_00000_0_00) begin
      n_err++;
      $display("[TB] FAIL async_reset got %b/%b want %b", act16, act2, 9'b1_00000_0_00);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < t.len(); i++) begin
      applyStimulus(t[i], 1'b1);
      n_vec++;
      if (act16 !== expv(0) || act2 !== expv(1)) begin
        n_err++;
        $display("[TB] FAIL post_reset char %0d got %b/%b want %b/%b", i, act16, act2, expv(0), expv(1));
      end
    end
    n_vec++;
    if (code16 !== 2'd1 || err16 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL post_reset_underflow got c=%0d e=%b want c=1 e=1", code16, err16);
    end
  endtask

  task automatic test_random();
    string junk = "bdeginfjorkxBE\t";
    applyClear();
    for (int w = 0; w < 300; w++) begin
      int pick = $urandom_range(99);
      int len;
      byte unsigned word[8];
      if ($urandom_range(39) == 0) applyClear();
      if (pick < 60) begin
        int k = (pick < 35) ? (($urandom_range(1) == 1) ? 2 : 0)
                            : (($urandom_range(1) == 1) ? 3 : 1);
        len = kws[k].len();
        for (int j = 0; j < len; j++) begin
          word[j] = kws[k][j];
          if ($urandom_range(1) == 1) word[j] = byte'(word[j] - 32);
        end
      end else begin
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) word[j] = junk[$urandom_range(junk.len() - 1)];
      end
      word[len] = 8'h20;
      for (int j = 0; j <= len; j++) begin
        if ($urandom_range(4) == 0) applyStimulus(8'($urandom_range(255)), 1'b0);
        applyStimulus(word[j], 1'b1);
        n_vec++;
        if (act16 !== expv(0) || act2 !== expv(1)) begin
          n_err++;
          $display("[TB] FAIL random word %0d char %0d got %b/%b want %b/%b", w, j, act16, act2, expv(0), expv(1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_balanced();
    test_underflow();
    test_mismatch_clear();
    test_overflow();
    test_valid_gaps();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
